fetch_unit: RTL

Instruction-fetch stage front end: owns the program counter, drives the instruction-memory address, and predicts the next PC with a small direct-mapped branch target buffer (BTB) and 2-bit saturating counters. It sits directly upstream of the IF/ID register and the hazard detection unit. It consumes `PC_stall` to hold the PC, and `update_PC` plus the corrected PC from decode to redirect after a misfetch. Its predictions and `PC_next` travel down IF/ID with the instruction.

---
 rtl/fetch_pkg.sv | 32 +++
 rtl/branch_target_buffer.sv | 78 +++++++
 rtl/fetch_unit.sv | 72 +++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned PC_W        = 16;
  localparam int unsigned INSTR_BYTES = 2;

  // 2-bit saturating branch counter encodings
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // One BTB line; tag is stored right-aligned in a full PC-width field so the
  // struct does not depend on the entry count.
  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] tag;
    logic [PC_W-1:0] target;
    logic [1:0]      ctr;
  } btb_entry_t;

  // Saturating counter increment
  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == CTR_ST) ? CTR_ST : 2'(c + 2'd1);
  endfunction

  // Saturating counter decrement
  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == CTR_SNT) ? CTR_SNT : 2'(c - 2'd1);
  endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit counters: one lookup port, one training port.
// Lookup reads the registered array, so a same-cycle write is seen next cycle.
module branch_target_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned ENTRIES = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            pred_taken_c,
  output logic [PC_W-1:0] pred_target_c,
  input  logic            wr_en,
  input  logic [PC_W-1:0] wr_pc,
  input  logic            wr_taken,
  input  logic [PC_W-1:0] wr_target
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  btb_entry_t btb_q [ENTRIES];
  btb_entry_t btb_d [ENTRIES];

  logic [IDX_W-1:0] rd_idx;
  logic [PC_W-1:0]  rd_tag;
  btb_entry_t       rd_entry;
  logic [IDX_W-1:0] wr_idx;
  logic [PC_W-1:0]  wr_tag;
  btb_entry_t       wr_entry;
  logic             wr_hit;

  // Lookup against the current PC; target forced to zero when not predicting taken
  always_comb begin
    rd_idx        = lookup_pc[IDX_W:1];
    rd_tag        = lookup_pc >> (IDX_W + 1);
    rd_entry      = btb_q[rd_idx];
    pred_taken_c  = rd_entry.valid && (rd_entry.tag == rd_tag) && rd_entry.ctr[1];
    pred_target_c = pred_taken_c ? rd_entry.target : '0;
  end

  // Training: update counter/target on hit, allocate on taken miss
  always_comb begin
    btb_d    = btb_q;
    wr_idx   = wr_pc[IDX_W:1];
    wr_tag   = wr_pc >> (IDX_W + 1);
    wr_entry = btb_q[wr_idx];
    wr_hit   = wr_entry.valid && (wr_entry.tag == wr_tag);
    if (wr_en) begin
      if (wr_hit) begin
        if (wr_taken) begin
          wr_entry.ctr    = ctr_inc(wr_entry.ctr);
          wr_entry.target = wr_target;
        end else begin
          wr_entry.ctr    = ctr_dec(wr_entry.ctr);
        end
        btb_d[wr_idx] = wr_entry;
      end else if (wr_taken) begin
        wr_entry.valid  = 1'b1;
        wr_entry.tag    = wr_tag;
        wr_entry.target = wr_target;
        wr_entry.ctr    = CTR_WT;
        btb_d[wr_idx]   = wr_entry;
      end
    end
  end

  // BTB storage; reset invalidates every line and drops any pending write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        btb_q[i] <= '0;
      end
    end else begin
      btb_q <= btb_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC register, next-PC selection and BTB prediction.
// Optional feature macro: FETCH_BRANCH_PREDICT_EN (BTB present when defined).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int unsigned BTB_ENTRIES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PC_stall,
  input  logic        update_PC,
  input  logic [15:0] branch_PC,
  input  logic        ID_btb_wen,
  input  logic [15:0] ID_PC,
  input  logic        ID_taken,
  input  logic [15:0] ID_target,
  output logic [15:0] PC_curr,
  output logic [15:0] PC_next,
  output logic        pred_taken,
  output logic [15:0] pred_target
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  assign PC_curr = pc_q;
  assign PC_next = pc_q + PC_W'(INSTR_BYTES);

`ifdef FETCH_BRANCH_PREDICT_EN
  branch_target_buffer #(
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk           (clk),
    .rst_n         (rst_n),
    .lookup_pc     (pc_q),
    .pred_taken_c  (pred_taken),
    .pred_target_c (pred_target),
    .wr_en         (ID_btb_wen),
    .wr_pc         (ID_PC),
    .wr_taken      (ID_taken),
    .wr_target     (ID_target)
  );
`else
  logic unused_btb_inputs;
  assign unused_btb_inputs = ^{ID_btb_wen, ID_PC, ID_taken, ID_target};
  assign pred_taken  = 1'b0;
  assign pred_target = '0;
`endif

  // Next-PC priority: redirect, then stall, then prediction, then sequential
  always_comb begin
    pc_d = PC_next;
    if (update_PC) begin
      pc_d = branch_PC;
    end else if (PC_stall) begin
      pc_d = pc_q;
    end else if (pred_taken) begin
      pc_d = pred_target;
    end
  end

  // PC register with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule
